nios_f_ocimem_arbiter: RTL and testbench
========================================

Name: nios_f_ocimem_arbiter

Overview:
Shares the Nios II on-chip debug memory (OCI RAM, single-port, 1-cycle registered read) between two requesters.
- CPU side: the monitor/slave Avalon port.
- JTAG side: the debug module's ocimem strobes, from the sysclk domain, with an auto-incrementing address pointer.

It sequences every RAM cycle, arbitrates contention with debug-aware priority plus anti-starvation, and returns read data to the winner. It sits between the JTAG sysclk logic, the CPU data master and the OCI RAM.

Parameters:
ADDR_W, 8, RAM word-address width (depth 2^ADDR_W)
DATA_W, 32, RAM data width
STARVE_LIMIT, 4, consecutive grants to the priority side, with the other side pending, before the other side is forced through (1..15)

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-high reset
debugack  in  1  CPU halted in debug mode; 1 gives JTAG priority
cpu_read  in  1  Avalon read, held until cpu_waitrequest=0
cpu_write  in  1  Avalon write, held until cpu_waitrequest=0
cpu_address  in  ADDR_W  CPU word address
cpu_writedata  in  DATA_W  CPU write data
cpu_waitrequest  out  1  low for exactly one cycle when the CPU access completes
cpu_readdata  out  DATA_W  valid when cpu_waitrequest=0 on a read
jtag_addr_ld  in  1  pulse: load pointer from jtag_addr_in
jtag_addr_in  in  ADDR_W  pointer load value
jtag_req  in  1  single-cycle access strobe
jtag_wr  in  1  sampled with jtag_req: 1=write, 0=read
jtag_wdata  in  DATA_W  sampled with jtag_req
jtag_ack  out  1  one-cycle completion pulse (registered)
jtag_rdata  out  DATA_W  last JTAG read word, held until the next JTAG read completes
jtag_overrun  out  1  sticky: jtag_req arrived while one was already pending
jtag_overrun_clr  in  1  clears jtag_overrun
jtag_ptr  out  ADDR_W  current JTAG address pointer
ram_addr  out  ADDR_W  registered RAM address
ram_wren  out  1  registered write enable, one cycle per write
ram_wdata  out  DATA_W  registered write data
ram_rdata  in  DATA_W  RAM read data, 1 cycle after ram_addr

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: state IDLE, cpu_waitrequest=1, cpu_readdata=0, jtag_ack=0, jtag_rdata=0, jtag_overrun=0, jtag_ptr=0, ram_addr=0, ram_wren=0, ram_wdata=0, pending flag=0, starve count=0.
- Reset mid-access aborts the access: no ack and no further RAM write. ram_wren drops asynchronously.
- JTAG capture:
  - jtag_req sets the pending flag and latches jtag_wr and jtag_wdata.
  - jtag_req while pending sets jtag_overrun; the new request is dropped and the latched request is unchanged.
  - If clear and set of jtag_overrun coincide, set wins.
- CPU request: cpu_read|cpu_write. If both are high, the access is treated as a write.
- FSM: IDLE -> ACC -> RESP -> IDLE.
  - IDLE, cycle T: if any request, pick a winner. ram_addr, ram_wren and ram_wdata are registered for T+1. Go to ACC.
  - ACC (T+1): RAM cycle; ram_wren=1 only for writes. Go to RESP.
  - RESP (T+2):
    - CPU winner: cpu_waitrequest=0 and cpu_readdata=ram_rdata (reads), registered from a T+2 capture.
    - JTAG winner: jtag_rdata captured from ram_rdata on reads. jtag_ack=1 at T+3. Pending flag clears. jtag_ptr increments, wrapping 2^ADDR_W-1 -> 0.
    - Go to IDLE.
  - A new grant can issue at T+3, so back-to-back throughput is one access per 3 cycles.
- cpu_waitrequest=1 in every cycle except the CPU RESP cycle, including while cpu_read/cpu_write are low.
- JTAG address is always jtag_ptr. jtag_addr_ld in the same cycle as a pointer increment: load wins. Load during an active JTAG access does not change that access's address.
- Arbitration in IDLE:
  - Only one side pending: that side wins.
  - Both pending: priority side = JTAG if debugack=1, else CPU. The priority side wins unless starve_cnt==STARVE_LIMIT, in which case the other side wins.
  - starve_cnt increments on each priority-side grant while the other side is pending. It clears when the other side is granted or is not pending.
  - debugack is sampled only in IDLE. A change mid-access has no effect.
- No combinational path from inputs to ram_* outputs.

Test Plan:
- Assert reset during ACC of a CPU write to 0x05 -> ram_wren=0 immediately, RAM[0x05] not written, cpu_waitrequest=1, jtag_ptr=0, no ack after release.
- RAM[0x10]=0xDEADBEEF; CPU read 0x10 at T -> ram_addr=0x10 at T+1; cpu_waitrequest=0 at T+2 only, with cpu_readdata=0xDEADBEEF.
- jtag_addr_ld with 0xFE, then three JTAG writes 0x11, 0x22, 0x33 -> RAM[0xFE]=0x11, RAM[0xFF]=0x22, RAM[0x00]=0x33; three jtag_ack pulses; jtag_ptr=0x01.
- debugack=0, STARVE_LIMIT=4, CPU reading continuously, one JTAG read pending -> grants CPU×4 then JTAG on the 5th; starve_cnt back to 0.
- debugack=1, CPU and JTAG requests in the same IDLE cycle -> JTAG granted first; CPU completes 3 cycles later.
- Second jtag_req one cycle after the first, while pending -> jtag_overrun=1, exactly one RAM access, one jtag_ack; jtag_overrun_clr -> 0.

Source files
------------

// File: rtl/nios_f_ocimem_arbiter_if.sv
// Bus bundle for the OCI RAM arbiter. It groups three sets of signals:
//   - the CPU Avalon slave port (cpu_*, debugack),
//   - the JTAG ocimem strobes and pointer (jtag_*),
//   - the single-port OCI RAM (ram_*).
// Modports:
//   slave  - the arbiter's view.
//   master - the environment's view (CPU, JTAG logic and RAM).
interface nios_f_ocimem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              debugack;
  logic              cpu_read;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_writedata;
  logic              cpu_waitrequest;
  logic [DATA_W-1:0] cpu_readdata;

  logic              jtag_addr_ld;
  logic [ADDR_W-1:0] jtag_addr_in;
  logic              jtag_req;
  logic              jtag_wr;
  logic [DATA_W-1:0] jtag_wdata;
  logic              jtag_ack;
  logic [DATA_W-1:0] jtag_rdata;
  logic              jtag_overrun;
  logic              jtag_overrun_clr;
  logic [ADDR_W-1:0] jtag_ptr;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  debugack, cpu_read, cpu_write, cpu_address, cpu_writedata,
    output cpu_waitrequest, cpu_readdata,
    input  jtag_addr_ld, jtag_addr_in, jtag_req, jtag_wr, jtag_wdata, jtag_overrun_clr,
    output jtag_ack, jtag_rdata, jtag_overrun, jtag_ptr,
    output ram_addr, ram_wren, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output debugack, cpu_read, cpu_write, cpu_address, cpu_writedata,
    input  cpu_waitrequest, cpu_readdata,
    output jtag_addr_ld, jtag_addr_in, jtag_req, jtag_wr, jtag_wdata, jtag_overrun_clr,
    input  jtag_ack, jtag_rdata, jtag_overrun, jtag_ptr,
    input  ram_addr, ram_wren, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/nios_f_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM (1-cycle registered read) between the
// CPU monitor port and the JTAG debug module's ocimem strobes.
// Every RAM cycle takes three clocks, so the throughput is one access per
// three cycles.
//
// Ports:
//   clk   - system clock; all logic is rising-edge.
//   reset - asynchronous, active-high.
//   bus   - nios_f_ocimem_arbiter_if.slave, which carries the CPU Avalon
//           port, the JTAG strobes and pointer, and the RAM port.
//
// state | meaning
// IDLE  | pick a winner; register ram_addr/ram_wren/ram_wdata
// ACC   | RAM cycle in progress (ram_wren high for writes)
// RESP  | RAM data valid; complete the CPU access or capture JTAG result
module nios_f_ocimem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic                  clk,
  input logic                  reset,
  nios_f_ocimem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_RESP} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t            state_q, state_d;
  logic              win_jtag_q, win_jtag_d;
  logic              win_wr_q, win_wr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_wren_q, ram_wren_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              cpu_wait_q, cpu_wait_d;
  logic              jtag_ack_q, jtag_ack_d;
  logic [DATA_W-1:0] jtag_rdata_q, jtag_rdata_d;
  logic              overrun_q, overrun_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              pend_q, pend_d;
  logic              pend_wr_q, pend_wr_d;
  logic [DATA_W-1:0] pend_wdata_q, pend_wdata_d;
  logic [3:0]        starve_q, starve_d;

  logic cpu_req;
  logic grant_jtag;
  logic prio_jtag;
  logic jtag_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      win_jtag_q   <= 1'b0;
      win_wr_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wren_q   <= 1'b0;
      ram_wdata_q  <= '0;
      cpu_wait_q   <= 1'b1;
      jtag_ack_q   <= 1'b0;
      jtag_rdata_q <= '0;
      overrun_q    <= 1'b0;
      ptr_q        <= '0;
      pend_q       <= 1'b0;
      pend_wr_q    <= 1'b0;
      pend_wdata_q <= '0;
      starve_q     <= '0;
    end else begin
      state_q      <= state_d;
      win_jtag_q   <= win_jtag_d;
      win_wr_q     <= win_wr_d;
      ram_addr_q   <= ram_addr_d;
      ram_wren_q   <= ram_wren_d;
      ram_wdata_q  <= ram_wdata_d;
      cpu_wait_q   <= cpu_wait_d;
      jtag_ack_q   <= jtag_ack_d;
      jtag_rdata_q <= jtag_rdata_d;
      overrun_q    <= overrun_d;
      ptr_q        <= ptr_d;
      pend_q       <= pend_d;
      pend_wr_q    <= pend_wr_d;
      pend_wdata_q <= pend_wdata_d;
      starve_q     <= starve_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    win_jtag_d   = win_jtag_q;
    win_wr_d     = win_wr_q;
    ram_addr_d   = ram_addr_q;
    ram_wren_d   = 1'b0;
    ram_wdata_d  = ram_wdata_q;
    cpu_wait_d   = 1'b1;
    jtag_ack_d   = 1'b0;
    jtag_rdata_d = jtag_rdata_q;
    starve_d     = starve_q;
    grant_jtag   = 1'b0;
    prio_jtag    = 1'b0;
    jtag_done    = 1'b0;
    cpu_req      = bus.cpu_read | bus.cpu_write;

    case (state_q)
      S_IDLE: begin
        if (cpu_req || pend_q) begin
          if (cpu_req && pend_q) begin
            prio_jtag  = bus.debugack;
            // Once the priority side has won STARVE_LIMIT times in a row
            // against a waiting requester, the other side gets one grant.
            grant_jtag = (starve_q == STARVE_MAX) ? !prio_jtag : prio_jtag;
            starve_d   = (grant_jtag == prio_jtag) ? starve_q + 4'd1 : 4'd0;
          end else begin
            grant_jtag = pend_q;
            starve_d   = 4'd0;
          end
          win_jtag_d = grant_jtag;
          if (grant_jtag) begin
            win_wr_d    = pend_wr_q;
            ram_addr_d  = ptr_q;
            ram_wdata_d = pend_wdata_q;
            ram_wren_d  = pend_wr_q;
          end else begin
            // Read and write together count as a write.
            win_wr_d    = bus.cpu_write;
            ram_addr_d  = bus.cpu_address;
            ram_wdata_d = bus.cpu_writedata;
            ram_wren_d  = bus.cpu_write;
          end
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        cpu_wait_d = win_jtag_q;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (win_jtag_q) begin
          jtag_done  = 1'b1;
          jtag_ack_d = 1'b1;
          if (!win_wr_q) begin
            jtag_rdata_d = bus.ram_rdata;
          end
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A request that arrives while one is already pending is dropped and
  // flagged. A clear that lands in the same cycle as a new overrun loses.
  always_comb begin
    pend_d       = pend_q;
    pend_wr_d    = pend_wr_q;
    pend_wdata_d = pend_wdata_q;
    overrun_d    = overrun_q;
    if (jtag_done) begin
      pend_d = 1'b0;
    end
    if (bus.jtag_req && pend_q) begin
      overrun_d = 1'b1;
    end else begin
      if (bus.jtag_req) begin
        pend_d       = 1'b1;
        pend_wr_d    = bus.jtag_wr;
        pend_wdata_d = bus.jtag_wdata;
      end
      if (bus.jtag_overrun_clr) begin
        overrun_d = 1'b0;
      end
    end
  end

  // A load beats the post-access increment. The address of the access in
  // flight is already held in ram_addr_q, so a load cannot disturb it.
  always_comb begin
    ptr_d = ptr_q;
    if (bus.jtag_addr_ld) begin
      ptr_d = bus.jtag_addr_in;
    end else if (jtag_done) begin
      ptr_d = ptr_q + ADDR_W'(1);
    end
  end

  assign bus.ram_addr        = ram_addr_q;
  assign bus.ram_wren        = ram_wren_q;
  assign bus.ram_wdata       = ram_wdata_q;
  assign bus.cpu_waitrequest = cpu_wait_q;
  // The RAM's output register already provides the registered read data.
  // Forward it only in the CPU read completion cycle.
  assign bus.cpu_readdata    = (state_q == S_RESP && !win_jtag_q && !win_wr_q) ?
                               bus.ram_rdata : '0;
  assign bus.jtag_ack        = jtag_ack_q;
  assign bus.jtag_rdata      = jtag_rdata_q;
  assign bus.jtag_overrun    = overrun_q;
  assign bus.jtag_ptr        = ptr_q;

endmodule

// File: tb/tb_nios_f_ocimem_arbiter.sv
module tb_nios_f_ocimem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  nios_f_ocimem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  nios_f_ocimem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // RAM model: single port, registered read
  logic [DW-1:0] ram_mem [0:255];
  always @(posedge clk) begin
    if (bus.ram_wren === 1'b1) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram_mem[bus.ram_addr];
  end

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_ack = 0, ack_cyc = -1;
  int n_cpu = 0, cpu_cyc = -1;

  // Transaction-level reference model
  logic [DW-1:0] mm [0:255];
  int free_at;
  bit t_valid, t_jtag, t_wr;
  int t_g;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_data;
  bit m_pend, m_lwr;
  logic [DW-1:0] m_ldata;
  int starve;
  bit e_wait, e_ack, e_wren, e_ovr, e_cpurd;
  logic [AW-1:0] e_addr, e_ptr;
  logic [DW-1:0] e_wdata, e_jrd, e_cpudata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    e_wait = 1; e_ack = 0; e_wren = 0; e_ovr = 0; e_cpurd = 0;
    e_addr = '0; e_ptr = '0; e_wdata = '0; e_jrd = '0; e_cpudata = '0;
    m_pend = 0; m_lwr = 0; m_ldata = '0; starve = 0; t_valid = 0; free_at = cyc;
  endtask

  // Inputs present in cycle cyc -> expected outputs in cycle cyc+1
  task automatic model_next();
    int n;
    bit cpu_req, jdone, pend_now, gj, pj;
    n = cyc + 1;
    cpu_req = bus.cpu_read | bus.cpu_write;
    pend_now = m_pend;
    jdone = t_valid && t_jtag && (cyc == t_g + 2);
    if (t_valid && t_wr && cyc == t_g + 1) mm[t_addr] = t_data;
    if (cyc >= free_at && (cpu_req || pend_now)) begin
      if (cpu_req && pend_now) begin
        pj = bus.debugack;
        gj = (starve == SL) ? !pj : pj;
        starve = (gj == pj) ? starve + 1 : 0;
      end else begin
        gj = pend_now;
        starve = 0;
      end
      t_valid = 1; t_g = cyc; t_jtag = gj;
      if (gj) begin
        t_wr = m_lwr; t_addr = e_ptr; t_data = m_ldata;
      end else begin
        t_wr = bus.cpu_write; t_addr = bus.cpu_address; t_data = bus.cpu_writedata;
      end
      free_at = cyc + 3;
    end
    e_wren = t_valid && (n == t_g + 1) && t_wr;
    if (t_valid && n == t_g + 1) begin
      e_addr = t_addr;
      if (t_wr) e_wdata = t_data;
    end
    e_wait = !(t_valid && !t_jtag && n == t_g + 2);
    e_cpurd = !e_wait && !t_wr;
    e_cpudata = mm[t_addr];
    e_ack = jdone;
    if (jdone && !t_wr) e_jrd = mm[t_addr];
    if (bus.jtag_addr_ld) e_ptr = bus.jtag_addr_in;
    else if (jdone) e_ptr = e_ptr + 8'd1;
    if (jdone) m_pend = 0;
    if (bus.jtag_req && !pend_now) begin
      m_pend = 1; m_lwr = bus.jtag_wr; m_ldata = bus.jtag_wdata;
    end
    if (bus.jtag_req && pend_now) e_ovr = 1;
    else if (bus.jtag_overrun_clr) e_ovr = 0;
  endtask

  task automatic compare();
    chk("waitrequest", bus.cpu_waitrequest, e_wait);
    chk("jtag_ack", bus.jtag_ack, e_ack);
    chk("ram_wren", bus.ram_wren, e_wren);
    chk("ram_addr", bus.ram_addr, e_addr);
    chk("jtag_ptr", bus.jtag_ptr, e_ptr);
    chk("jtag_overrun", bus.jtag_overrun, e_ovr);
    chk("jtag_rdata", bus.jtag_rdata, e_jrd);
    if (e_wren) chk("ram_wdata", bus.ram_wdata, e_wdata);
    if (e_cpurd) chk("cpu_readdata", bus.cpu_readdata, e_cpudata);
    if (bus.jtag_ack === 1'b1) begin n_ack++; ack_cyc = cyc; end
    if (bus.cpu_waitrequest === 1'b0) begin n_cpu++; cpu_cyc = cyc; end
  endtask

  task automatic tick();
    model_next();
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic idle_inputs();
    bus.cpu_read = 0; bus.cpu_write = 0; bus.jtag_req = 0;
    bus.jtag_addr_ld = 0; bus.jtag_overrun_clr = 0;
  endtask

  initial begin
    logic [DW-1:0] init05;
    int a0, c0, start, guard;
    bit cpu_busy, cpu_fin;
    int r;

    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = $urandom;
      mm[i] = ram_mem[i];
    end
    ram_mem[8'h10] = 32'hDEADBEEF; mm[8'h10] = 32'hDEADBEEF;
    init05 = ram_mem[8'h05];
    bus.debugack = 0; bus.cpu_address = '0; bus.cpu_writedata = '0;
    bus.jtag_addr_in = '0; bus.jtag_wr = 0; bus.jtag_wdata = '0;
    idle_inputs();

    #1 reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    cyc = 0;
    model_reset();
    compare();
    chk("rst_wait", bus.cpu_waitrequest, 1'b1);
    chk("rst_rdata", bus.cpu_readdata, 32'h0);
    chk("rst_ptr", bus.jtag_ptr, 8'h00);
    repeat (2) tick();

    // CPU read of 0x10
    bus.cpu_read = 1; bus.cpu_address = 8'h10;
    tick();
    chk("rd_addr_T1", bus.ram_addr, 8'h10);
    chk("rd_wait_T1", bus.cpu_waitrequest, 1'b1);
    tick();
    chk("rd_wait_T2", bus.cpu_waitrequest, 1'b0);
    chk("rd_data_T2", bus.cpu_readdata, 32'hDEADBEEF);
    tick();
    chk("rd_wait_T3", bus.cpu_waitrequest, 1'b1);
    bus.cpu_read = 0;
    repeat (2) tick();

    // Reset during ACC of a CPU write to 0x05
    bus.cpu_write = 1; bus.cpu_address = 8'h05; bus.cpu_writedata = 32'hA5A5A5A5;
    tick();
    chk("abort_wren_before", bus.ram_wren, 1'b1);
    reset = 1;
    #1;
    chk("abort_wren_async", bus.ram_wren, 1'b0);
    chk("abort_wait", bus.cpu_waitrequest, 1'b1);
    bus.cpu_write = 0;
    a0 = n_ack;
    @(negedge clk);
    cyc++;
    reset = 0;
    model_reset();
    compare();
    repeat (4) tick();
    chk("abort_mem05", ram_mem[8'h05], init05);
    chk("abort_noack", n_ack - a0, 0);
    chk("abort_ptr", bus.jtag_ptr, 8'h00);

    // JTAG pointer load and three writes across the wrap
    bus.jtag_addr_ld = 1; bus.jtag_addr_in = 8'hFE;
    tick();
    bus.jtag_addr_ld = 0;
    a0 = n_ack;
    for (int i = 1; i <= 3; i++) begin
      bus.jtag_req = 1; bus.jtag_wr = 1; bus.jtag_wdata = 32'(i * 32'h11);
      tick();
      bus.jtag_req = 0;
      repeat (4) tick();
    end
    chk("jw_memFE", ram_mem[8'hFE], 32'h11);
    chk("jw_memFF", ram_mem[8'hFF], 32'h22);
    chk("jw_mem00", ram_mem[8'h00], 32'h33);
    chk("jw_acks", n_ack - a0, 3);
    chk("jw_ptr", bus.jtag_ptr, 8'h01);

    // Overrun: second request while the first is pending
    a0 = n_ack;
    bus.jtag_req = 1; bus.jtag_wr = 0;
    tick();
    bus.jtag_req = 1;
    tick();
    bus.jtag_req = 0;
    chk("ovr_set", bus.jtag_overrun, 1'b1);
    repeat (5) tick();
    chk("ovr_one_ack", n_ack - a0, 1);
    chk("ovr_ptr", bus.jtag_ptr, 8'h02);
    bus.jtag_overrun_clr = 1;
    tick();
    bus.jtag_overrun_clr = 0;
    chk("ovr_clr", bus.jtag_overrun, 1'b0);
    repeat (2) tick();

    // debugack=1: both pending in the same IDLE cycle, JTAG first
    bus.debugack = 1;
    bus.cpu_write = 1; bus.cpu_address = 8'h40; bus.cpu_writedata = 32'h12345678;
    tick();
    bus.jtag_req = 1; bus.jtag_wr = 0;
    tick();
    bus.jtag_req = 0;
    tick();
    bus.cpu_write = 0; bus.cpu_read = 1; bus.cpu_address = 8'h41;
    start = cyc;
    repeat (5) tick();
    chk("dbg_jtag_ack_cyc", ack_cyc - start, 3);
    chk("dbg_cpu_done_cyc", cpu_cyc - start, 5);
    tick();
    bus.cpu_read = 0;
    bus.debugack = 0;
    repeat (3) tick();

    // Anti-starvation with CPU priority
    bus.cpu_write = 1; bus.cpu_address = 8'h50; bus.cpu_writedata = 32'hCAFEF00D;
    tick();
    bus.jtag_req = 1; bus.jtag_wr = 0;
    tick();
    bus.jtag_req = 0;
    tick();
    bus.cpu_write = 0; bus.cpu_read = 1; bus.cpu_address = 8'h60;
    a0 = n_ack; c0 = n_cpu; guard = 0;
    while (n_ack == a0 && guard < 40) begin tick(); guard++; end
    chk("starve_jtag_ack", n_ack - a0, 1);
    chk("starve_cpu_grants", n_cpu - c0, 4);
    guard = 0;
    while (e_wait && guard < 10) begin tick(); guard++; end
    chk("starve_drain", e_wait, 1'b0);
    tick();
    bus.cpu_read = 0;
    repeat (3) tick();

    // Randomized traffic
    cpu_busy = 0; cpu_fin = 0;
    for (int k = 0; k < 3000; k++) begin
      if (cpu_fin) begin
        cpu_busy = 0; cpu_fin = 0; bus.cpu_read = 0; bus.cpu_write = 0;
      end
      if (cpu_busy && !e_wait) begin
        cpu_fin = 1;
      end else if (!cpu_busy && $urandom_range(2) == 0) begin
        cpu_busy = 1;
        r = $urandom_range(2);
        bus.cpu_read = (r != 1);
        bus.cpu_write = (r != 0);
        bus.cpu_address = AW'($urandom);
        bus.cpu_writedata = $urandom;
      end
      bus.jtag_req = ($urandom_range(4) == 0);
      bus.jtag_wr = $urandom_range(1);
      bus.jtag_wdata = $urandom;
      bus.jtag_addr_ld = ($urandom_range(24) == 0);
      bus.jtag_addr_in = AW'($urandom);
      bus.jtag_overrun_clr = ($urandom_range(11) == 0);
      if ($urandom_range(24) == 0) bus.debugack = ~bus.debugack;
      tick();
    end
    idle_inputs();
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
